// File: rtl/fetch_buffer_pkg.sv
// Shared pipeline types for fetch and decode: word width and the {pc, instr} queue entry.
package fetch_buffer_pkg;

  localparam int WORD          = 32;
  localparam int FETCH_ENTRY_W = 2 * WORD;

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Storage and read/write pointers for the fetch queue. The pointers carry one
// extra wrap bit, so full and empty can be told apart when the indices are equal.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               pushEntry,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW:0]    rdPtr;
  logic [AW:0]    wrPtr;
  logic           doPush;
  logic           doPop;

  assign empty  = (rdPtr == wrPtr);
  assign full   = (rdPtr[AW-1:0] == wrPtr[AW-1:0]) && (rdPtr[AW] != wrPtr[AW]);
  assign count  = wrPtr - rdPtr;
  assign head   = mem[rdPtr[AW-1:0]];
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // A write that coincides with flush or reset lands in a slot the reset pointers ignore.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushEntry;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: owns the fetch PC, issues one read per cycle and queues {pc, instr}.
// Optional FETCH_BUF_BYPASS_EN shows a response at the head in its arrival cycle when the queue is empty.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   redirect,
  input  logic [WORD-1:0]        redirectPc,
  output logic                   imemReq,
  output logic [WORD-1:0]        imemAddr,
  input  logic [WORD-1:0]        imemData,
  output logic [WORD-1:0]        pcD,
  output logic [WORD-1:0]        instrD,
  output logic                   validD,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WORD-1:0] pc;
  logic [WORD-1:0] inflightPc;
  logic            inflight;

  fetch_entry_t    fifoHead;
  fetch_entry_t    pushEntry;
  logic [CW-1:0]   fifoCount;
  logic            fifoFull;
  logic            fifoEmpty;
  logic            push;
  logic            fifoPop;
  logic            pop;
  logic [CW:0]     occupancy;

  assign pushEntry = '{pc: inflightPc, instr: imemData};

`ifdef FETCH_BUF_BYPASS_EN
  logic bypass;
  assign bypass  = fifoEmpty & inflight & ~redirect;
  assign validD  = ~redirect & (~fifoEmpty | inflight);
  assign pcD     = fifoEmpty ? inflightPc : fifoHead.pc;
  assign instrD  = fifoEmpty ? imemData   : fifoHead.instr;
  // A bypassed response consumed this cycle never enters storage.
  assign push    = inflight & ~redirect & ~(bypass & en);
  assign fifoPop = en & ~fifoEmpty & ~redirect;
`else
  assign validD  = ~redirect & ~fifoEmpty;
  assign pcD     = fifoHead.pc;
  assign instrD  = fifoHead.instr;
  assign push    = inflight & ~redirect;
  assign fifoPop = validD & en;
`endif

  assign pop       = validD & en;
  // Occupancy once this cycle's response and pop settle; a new request needs a free slot beyond that.
  assign occupancy = {1'b0, fifoCount} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign imemReq   = reset & ~redirect & (occupancy < (CW+1)'(DEPTH));
  assign imemAddr  = pc;
  assign count     = fifoCount;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= RESET_PC;
    end else if (redirect) begin
      pc         <= redirectPc & ~(WORD'(3));
      inflight   <= 1'b0;
    end else if (imemReq) begin
      pc         <= pc + WORD'(4);
      inflight   <= 1'b1;
      inflightPc <= pc;
    end else begin
      inflight   <= 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (fifoPop),
    .flush     (redirect),
    .head      (fifoHead),
    .count     (fifoCount),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  overflowCheck: assert property (@(posedge clk) disable iff (!reset) push |-> !fifoFull);

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a scoreboard queue of expected PCs is checked on every pop.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int              DEPTH    = 4;
  localparam logic [WORD-1:0] RESET_PC = 32'h0;
  localparam logic [WORD-1:0] XORPAT   = 32'hA5A5_0000;
`ifdef FETCH_BUF_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic            redirect;
  logic [WORD-1:0] redirectPc;
  logic            imemReq;
  logic [WORD-1:0] imemAddr;
  logic [WORD-1:0] imemData = '0;
  logic [WORD-1:0] pcD;
  logic [WORD-1:0] instrD;
  logic            validD;
  logic [2:0]      count;

  int              vectors     = 0;
  int              miscompares = 0;
  int              popCnt      = 0;
  int              p0;
  logic [WORD-1:0] expQ[$];
  logic [WORD-1:0] monExp;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemData   (imemData),
    .pcD        (pcD),
    .instrD     (instrD),
    .validD     (validD),
    .count      (count)
  );

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge clk) if (imemReq) imemData <= imemAddr ^ XORPAT;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic loadStream(input logic [WORD-1:0] start);
    expQ.delete();
    for (int i = 0; i < 64; i++) expQ.push_back(start + WORD'(4 * i));
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Every accepted head entry must be the next expected PC with its matching instruction.
  always begin
    @(negedge clk);
    #3;
    if (reset && validD && en) begin
      chk("scoreboard_empty", 32'(expQ.size() == 0), 32'd0);
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        chk("pcD", pcD, monExp);
        chk("instrD", instrD, monExp ^ XORPAT);
      end
      popCnt++;
    end
  end

  initial begin
    reset = 1'b0; en = 1'b0; redirect = 1'b0; redirectPc = '0;
    tick(); tick();
    chk("rst_validD",   32'(validD),  32'd0);
    chk("rst_count",    32'(count),   32'd0);
    chk("rst_imemReq",  32'(imemReq), 32'd0);
    chk("rst_imemAddr", imemAddr,     RESET_PC);

    // Streaming from reset with en held high.
    loadStream(RESET_PC); en = 1'b1; reset = 1'b1; p0 = popCnt; #1;
    chk("c0_imemReq",  32'(imemReq), 32'd1);
    chk("c0_imemAddr", imemAddr,     RESET_PC);
    for (int c = 1; c < 10; c++) begin
      tick();
      chk($sformatf("t1_validD_c%0d", c), 32'(validD), 32'(c >= LAT));
    end
    tick();
    chk("t1_pops", 32'(popCnt - p0), 32'(10 - LAT));

    // Decode stalled: queue fills to DEPTH and requests stop.
    reset = 1'b0; en = 1'b0; tick();
    loadStream(RESET_PC); reset = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("t2_count_c%0d", c), 32'(count), 32'((c - 1 > DEPTH) ? DEPTH : c - 1));
      chk($sformatf("t2_imemReq_c%0d", c), 32'(imemReq), 32'(c < 4));
    end
    en = 1'b1; p0 = popCnt; #1;
    chk("t2_validD_release", 32'(validD), 32'd1);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("t2_nogap_%0d", c), 32'(validD), 32'd1);
    end
    chk("t2_pops", 32'(popCnt - p0), 32'd8);

    // Redirect with count = 3 and a read in flight.
    reset = 1'b0; en = 1'b0; tick();
    loadStream(RESET_PC); reset = 1'b1;
    repeat (4) tick();
    chk("t3_pre_count", 32'(count), 32'd3);
    redirect = 1'b1; redirectPc = 32'h103; #1;
    chk("t3_redir_validD",  32'(validD),  32'd0);
    chk("t3_redir_imemReq", 32'(imemReq), 32'd0);
    tick();
    redirect = 1'b0; en = 1'b1; loadStream(32'h100); #1;
    chk("t3_count",    32'(count),   32'd0);
    chk("t3_validD",   32'(validD),  32'd0);
    chk("t3_imemReq",  32'(imemReq), 32'd1);
    chk("t3_imemAddr", imemAddr,     32'h100);
    tick();
    chk("t3_validD_n2", 32'(validD), 32'(LAT == 1));
    tick();
    chk("t3_validD_n3", 32'(validD), 32'd1);

    // Redirect with en high while a response arrives: no pop, no push.
    tick();
    redirect = 1'b1; redirectPc = 32'h200; p0 = popCnt; #1;
    chk("t4_redir_validD",  32'(validD),  32'd0);
    chk("t4_redir_imemReq", 32'(imemReq), 32'd0);
    tick();
    redirect = 1'b0; #1;
    chk("t4_pops_redir", 32'(popCnt - p0), 32'd0);
    chk("t4_count",      32'(count),       32'd0);
    chk("t4_imemAddr",   imemAddr,         32'h200);
    loadStream(32'h200); p0 = popCnt;
    repeat (6) tick();
    chk("t4_pops", 32'(popCnt - p0), 32'(6 - LAT));

    // Reset mid-stream with a read in flight.
    reset = 1'b0; tick();
    chk("t5_count",    32'(count),   32'd0);
    chk("t5_validD",   32'(validD),  32'd0);
    chk("t5_imemReq",  32'(imemReq), 32'd0);
    chk("t5_imemAddr", imemAddr,     RESET_PC);
    loadStream(RESET_PC); reset = 1'b1; p0 = popCnt;
    repeat (5) tick();
    chk("t5_pops", 32'(popCnt - p0), 32'(5 - LAT));

    // Alternating stall: order preserved, occupancy bounded.
    for (int i = 0; i < 20; i++) begin
      en = 1'(i % 2);
      tick();
      chk($sformatf("t6_count_le_%0d", i), 32'(count <= 3'(DEPTH)), 32'd1);
    end
    en = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction prefetch buffer between the instruction memory and the decode stage. It owns the fetch PC, issues one word read per cycle to a synchronous instruction memory with 1-cycle read latency, and queues returned {pc, instr} pairs in a small FIFO. Decode drains the FIFO under its `en` (not stalled) signal. A redirect from the memory stage (taken branch/jump, `PCSrcM`) flushes the buffer and any in-flight read, then restarts fetch at the target.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `RESET_PC`, 32'h0: first fetch address after reset.
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low; 0 at a posedge clears all state.
- `en` in 1: decode accepts the head entry this cycle (pop when `validD & en`).
- `redirect` in 1: flush and restart fetch (driven by `PCSrcM`).
- `redirectPc` in `WORD`: restart address; bits [1:0] forced to 0.
- `imemReq` out 1: read request this cycle.
- `imemAddr` out `WORD`: read address, word aligned.
- `imemData` in `WORD`: read data, valid the cycle after an accepted request.
- `pcD` out `WORD`: PC of head entry.
- `instrD` out `WORD`: instruction of head entry.
- `validD` out 1: head entry valid.
- `count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- State: `pc`, FIFO (rd/wr pointers with one extra wrap bit), `inflight` flag, `inflightPc`.
- Request rule: `imemReq = !redirect & (count + inflight - pop < DEPTH)`, where `pop = validD & en`. `imemAddr = pc`. On request: `pc <= pc + 4`, `inflight <= 1`, `inflightPc <= pc`; otherwise `inflight <= 0`.
- Response: when `inflight` = 1, push {`inflightPc`, `imemData`}. Space is guaranteed by the request rule; overflow is a design error (assertion).
- Pop: head advances when `validD & en`. Push and pop in the same cycle leave `count` unchanged. Pop on empty is ignored.
- Redirect (priority over push, pop and request): FIFO is emptied, `inflight <= 0` (the next-cycle response is discarded), `pc <= {redirectPc[WORD-1:2], 2'b00}`, `imemReq = 0`, and `validD` is forced to 0 in that cycle. Fetch of the target is requested the following cycle.
- Pointer wrap: arithmetic is modulo DEPTH on the index. Full when indices are equal and wrap bits differ; empty when both are equal.
- Reset (any time, including with a read in flight): `pc <= RESET_PC`, `count` = 0, `inflight` = 0. A response arriving after reset is dropped.
- Reset values of outputs: `validD` = 0, `count` = 0, `imemReq` = 0 while `reset` = 0, `imemAddr` = `RESET_PC`. `pcD`/`instrD` are don't-care while `validD` = 0; the bench must not check them.

## Timing
- Outputs `pcD`, `instrD` and `validD` are combinational from the FIFO head (or the bypass path). `imemReq`/`imemAddr` are combinational from state plus `en`/`redirect`.
- Cycle 0 = first cycle with `reset` = 1: request `RESET_PC`. Cycle 1: data returns. Cycle 2: `validD` = 1 (cycle 1 with bypass).
- Steady state with `en` = 1: one instruction per cycle, for any DEPTH ≥ 2.
- Redirect in cycle N: request for the target in N+1, data in N+2, `validD` in N+3 (N+2 with bypass).
- With `en` = 0, requests stop once `count + inflight` = DEPTH. No request is issued while full, and no entry is lost.

## Configuration
- `FETCH_BUF_BYPASS_EN` defined: when the FIFO is empty and a response arrives (not redirected), the head outputs show it in the same cycle (`validD` = 1). If `en` = 1, the entry is consumed without being written. If `en` = 0, it is written as normal.
- Undefined: every response passes through the FIFO, adding one cycle of latency. No other behaviour differs.

## Structure
- `WORD` stays in `consts.v`. Add `FETCH_ENTRY_W` (2*`WORD`) there, and add a `fetch_entry_t` {pc, instr} typedef to the shared pipeline package used by fetch and decode.
- One sub-module, `fetch_fifo`: parameterised storage plus pointers. It has push/pop/flush inputs and head/count/full/empty outputs. Request throttling, PC and redirect handling stay in `fetch_buffer`.

## Test plan
- Reset release, `en` = 1, memory returns `addr ^ 32'hA5A5_0000` → `validD` first in cycle 2 with `pcD` = 0. `pcD` then increases 0, 4, 8, … once per cycle, with `instrD` matching.
- `en` = 0 for 10 cycles after reset, DEPTH = 4 → `count` saturates at 4, `imemReq` = 0 while full. On releasing `en`, entries pop in order 0, 4, 8, 12, 16 with no gap and no duplicate.
- Redirect to 32'h103 while a read is in flight and `count` = 3 → next cycle `count` = 0 and `validD` = 0, then a request to 32'h100. The first `pcD` after the redirect is 32'h100, and the discarded response never appears.
- Redirect and `en` = 1 in the same cycle as a response arrives → no pop counted and no push. `count` goes to 0.
- `reset` = 0 asserted mid-stream with a read in flight → after release the first `pcD` is `RESET_PC`, and the stale data is never output.
- With `FETCH_BUF_BYPASS_EN`: first `validD` in cycle 1. Alternate `en` 1/0 → order is preserved and `count` never exceeds DEPTH.
